multi_edge_detector: RTL and testbench

Multi-channel, parametrised edge detector with input synchronisation, per-channel debounce filtering and per-channel edge-mode selection. It also provides sticky pending flags and an aggregated interrupt. It sits between raw asynchronous inputs (buttons, external strobes, status lines) and the control logic or register file that consumes edge events. It is the general-purpose successor to the single-bit rising/falling detector.

---
 rtl/edge_det_pkg.sv | 17 +
 rtl/edge_det_chan.sv | 133 +++++++++++++
 rtl/multi_edge_detector.sv | 49 ++++
 tb/tb_multi_edge_detector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared types and default parameters for the multi-channel edge detector.
// Optional event counters are enabled with MULTI_EDGE_DETECTOR_COUNT_EN.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int DEF_CH          = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 3;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, debounce filter, edge pulses, sticky pending flag
// and, when MULTI_EDGE_DETECTOR_COUNT_EN is defined, a saturating event counter.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             event_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int DC_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEB_CYCLES);

    logic s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = sig_i;
        end
    endgenerate

    logic [DC_W-1:0] dc_q, dc_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            event_q, event_d;
    logic            pending_q, pending_d;
    edge_mode_t      mode;

    assign mode = edge_mode_t'(mode_i);

    // The level only flips after s has disagreed with it for DEB_CYCLES+1 edges.
    always_comb begin
        dc_d      = '0;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        event_d   = 1'b0;
        pending_d = pending_q;
        if (s != level_q) begin
            if (dc_q == DC_MAX) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                dc_d = dc_q + DC_W'(1);
            end
        end
        event_d = (rise_d && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
                  (fall_d && (mode == EDGE_FALL || mode == EDGE_BOTH));
        if (event_q) begin
            pending_d = 1'b1;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dc_q      <= '0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            event_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            dc_q      <= dc_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            event_q   <= event_d;
            pending_q <= pending_d;
        end
    end

    assign level_o   = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign event_o   = event_q;
    assign pending_o = pending_q;

`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A clear coinciding with an event restarts the count at one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = event_q ? CNT_W'(1) : '0;
        end else if (event_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with sticky pending flags and an irq.
// Define MULTI_EDGE_DETECTOR_COUNT_EN to add per-channel saturating event counters.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int CH          = DEF_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH-1:0]       sig_i,
    input  logic [2*CH-1:0]     mode_i,
    input  logic [CH-1:0]       clr_i,
    output logic [CH-1:0]       level_o,
    output logic [CH-1:0]       rise_o,
    output logic [CH-1:0]       fall_o,
    output logic [CH-1:0]       event_o,
    output logic [CH-1:0]       pending_o,
    output logic                irq_o,
    output logic [CH*CNT_W-1:0] cnt_o
);

    generate
        for (genvar n = 0; n < CH; n++) begin : g_chan
            edge_det_chan #(
                .SYNC_STAGES(SYNC_STAGES),
                .DEB_CYCLES (DEB_CYCLES),
                .CNT_W      (CNT_W)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .sig_i    (sig_i[n]),
                .mode_i   (mode_i[2*n +: 2]),
                .clr_i    (clr_i[n]),
                .level_o  (level_o[n]),
                .rise_o   (rise_o[n]),
                .fall_o   (fall_o[n]),
                .event_o  (event_o[n]),
                .pending_o(pending_o[n]),
                .cnt_o    (cnt_o[n*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign irq_o = |pending_o;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector with CH=4, SYNC_STAGES=2, DEB_CYCLES=3, CNT_W=4.
// Counter checks follow MULTI_EDGE_DETECTOR_COUNT_EN.
module tb_multi_edge_detector;

    localparam int LAT = 6;  // input applied after edge c is seen on outputs after edge c+6

    logic        clk;
    logic        reset;
    logic [3:0]  sig_i;
    logic [7:0]  mode_i;
    logic [3:0]  clr_i;
    logic [3:0]  level_o, rise_o, fall_o, event_o, pending_o;
    logic        irq_o;
    logic [15:0] cnt_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] evt;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [3:0] sig;
        logic [7:0] mode;
        logic [3:0] clr;
        int         hold;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] evt;
        logic [3:0] level;
        logic [3:0] pend;
    } vec_t;

    vec_t       vecs[10];
    logic [3:0] lvl_exp;
    logic [3:0] sat_exp, one_exp;

    multi_edge_detector #(
        .CH(4), .SYNC_STAGES(2), .DEB_CYCLES(3), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .sig_i(sig_i), .mode_i(mode_i), .clr_i(clr_i),
        .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .event_o(event_o),
        .pending_o(pending_o), .irq_o(irq_o), .cnt_o(cnt_o)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int at, input logic [3:0] r, input logic [3:0] f,
                            input logic [3:0] ev);
        exp_t e;
        e.cyc = at; e.rise = r; e.fall = f; e.evt = ev;
        if ((r | f) != 4'b0) exp_q.push_back(e);
    endtask

    // event = (rise & mode[0]) | (fall & mode[1]) with the mode currently driven
    task automatic push_pulse(input int at, input logic [3:0] r, input logic [3:0] f);
        logic [3:0] ev;
        for (int n = 0; n < 4; n++) ev[n] = (r[n] & mode_i[2*n]) | (f[n] & mode_i[2*n+1]);
        push_exp(at, r, f, ev);
    endtask

    task automatic drive_stable(input logic [3:0] v, input int hold);
        sig_i = v;
        push_pulse(cyc + LAT, v & ~lvl_exp, ~v & lvl_exp);
        lvl_exp = v;
        repeat (hold) @(negedge clk);
    endtask

    // scoreboard: every pulse cycle must match the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL pulse_missing: got none, expected rise=%b fall=%b event=%b at cycle %0d",
                     e.rise, e.fall, e.evt, e.cyc);
        end
        if ((rise_o | fall_o | event_o) != 4'b0) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("pulse_rise", 32'(rise_o), 32'(e.rise));
                check("pulse_fall", 32'(fall_o), 32'(e.fall));
                check("pulse_event", 32'(event_o), 32'(e.evt));
            end else begin
                checks++;
                failures++;
                $display("FAIL pulse_unexpected: got rise=%b fall=%b event=%b at cycle %0d, expected none",
                         rise_o, fall_o, event_o, cyc);
            end
        end
    end

    initial begin
`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
        sat_exp = 4'hF;
        one_exp = 4'h1;
`else
        sat_exp = 4'h0;
        one_exp = 4'h0;
`endif
        //            sig      mode   clr    hold rise     fall     evt      level    pend
        vecs[0] = '{4'hF ^ 4'hF, 8'hE4, 4'h0, 8, 4'b0000, 4'b1111, 4'b1100, 4'b0000, 4'b1100};
        vecs[1] = '{4'b0000, 8'hE4, 4'hF, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2] = '{4'b1111, 8'hE4, 4'h0, 8, 4'b1111, 4'b0000, 4'b1010, 4'b1111, 4'b1010};
        vecs[3] = '{4'b1110, 8'hE4, 4'h0, 3, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1010};
        vecs[4] = '{4'b1111, 8'hE4, 4'h0, 8, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1010};
        vecs[5] = '{4'b1110, 8'hE4, 4'h0, 4, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b1010};
        vecs[6] = '{4'b1110, 8'hE4, 4'h0, 8, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 4'b1010};
        vecs[7] = '{4'b0101, 8'hE4, 4'h0, 8, 4'b0001, 4'b1010, 4'b1000, 4'b0101, 4'b1010};
        vecs[8] = '{4'b0101, 8'hE4, 4'hF, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000};
        vecs[9] = '{4'b1010, 8'h1B, 4'h0, 8, 4'b1010, 4'b0101, 4'b0001, 4'b1010, 4'b0001};

        // reset state with all inputs high
        reset  = 1'b1;
        sig_i  = 4'hF;
        mode_i = 8'h00;
        clr_i  = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level_o), 32'h0);
        check("rst_rise", 32'(rise_o), 32'h0);
        check("rst_fall", 32'(fall_o), 32'h0);
        check("rst_event", 32'(event_o), 32'h0);
        check("rst_pending", 32'(pending_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_cnt", 32'(cnt_o), 32'h0);
        reset = 1'b0;
        push_pulse(cyc + LAT, 4'hF, 4'h0);
        repeat (LAT - 1) @(negedge clk);
        check("rst_level_early", 32'(level_o), 32'h0);
        @(negedge clk);
        check("rst_level_after", 32'(level_o), 32'hF);
        repeat (3) @(negedge clk);

        // table-driven: glitches, modes, independence, pending clears
        for (int i = 0; i < 10; i++) begin
            sig_i  = vecs[i].sig;
            mode_i = vecs[i].mode;
            clr_i  = vecs[i].clr;
            push_exp(cyc + LAT, vecs[i].rise, vecs[i].fall, vecs[i].evt);
            repeat (vecs[i].hold) @(negedge clk);
            check($sformatf("vec%0d_level", i), 32'(level_o), 32'(vecs[i].level));
            check($sformatf("vec%0d_pending", i), 32'(pending_o), 32'(vecs[i].pend));
            check($sformatf("vec%0d_irq", i), 32'(irq_o), 32'(vecs[i].pend != 4'b0));
        end
        clr_i   = 4'h0;
        lvl_exp = 4'b1010;

        // pending / irq on ch2 (fall mode)
        mode_i = 8'hE4;
        clr_i  = 4'hF;
        repeat (2) @(negedge clk);
        clr_i = 4'h0;
        check("pend_cleared", 32'(pending_o), 32'h0);
        drive_stable(4'b1110, 8);
        check("pend_rise_noevt", 32'(pending_o), 32'h0);
        drive_stable(4'b1010, LAT + 1);
        check("pend_set", 32'(pending_o), 32'b0100);
        check("pend_irq", 32'(irq_o), 32'h1);
        clr_i = 4'b0100;
        @(negedge clk);
        clr_i = 4'h0;
        check("pend_lone_clr", 32'(pending_o), 32'h0);
        check("pend_lone_clr_irq", 32'(irq_o), 32'h0);
        drive_stable(4'b1110, 8);
        drive_stable(4'b1010, LAT);
        clr_i = 4'b0100;
        @(negedge clk);
        clr_i = 4'h0;
        check("pend_set_wins", 32'(pending_o), 32'b0100);
        check("pend_set_wins_irq", 32'(irq_o), 32'h1);
        clr_i = 4'b0100;
        @(negedge clk);
        clr_i = 4'h0;
        check("pend_clr_again", 32'(pending_o), 32'h0);
        check("pend_clr_again_irq", 32'(irq_o), 32'h0);

        // counter on ch1 (rise mode): saturation and clear-with-event
        clr_i = 4'hF;
        @(negedge clk);
        clr_i = 4'h0;
        check("cnt_cleared", 32'(cnt_o), 32'h0);
        for (int i = 0; i < 15; i++) begin
            drive_stable(lvl_exp & ~4'b0010, 5);
            drive_stable(lvl_exp | 4'b0010, 5);
        end
        repeat (3) @(negedge clk);
        check("cnt_ch1_15", 32'(cnt_o[7:4]), 32'(sat_exp));
        for (int i = 0; i < 5; i++) begin
            drive_stable(lvl_exp & ~4'b0010, 5);
            drive_stable(lvl_exp | 4'b0010, 5);
        end
        repeat (3) @(negedge clk);
        check("cnt_ch1_sat", 32'(cnt_o[7:4]), 32'(sat_exp));
        check("cnt_others", 32'({cnt_o[15:8], cnt_o[3:0]}), 32'h0);
        drive_stable(lvl_exp & ~4'b0010, 8);
        drive_stable(lvl_exp | 4'b0010, LAT);
        clr_i = 4'b0010;
        @(negedge clk);
        clr_i = 4'h0;
        check("cnt_clr_with_event", 32'(cnt_o[7:4]), 32'(one_exp));
        check("cnt_clr_pend", 32'(pending_o[1]), 32'h1);

        // reset two cycles into the ch3 debounce window
        drive_stable(4'b0000, 10);
        sig_i = 4'b1000;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_level", 32'(level_o), 32'h0);
        check("midrst_pending", 32'(pending_o), 32'h0);
        reset = 1'b0;
        push_pulse(cyc + LAT, 4'b1000, 4'b0000);
        lvl_exp = 4'b1000;
        @(negedge clk);
        check("midrst_no_orig_rise", 32'(rise_o), 32'h0);
        repeat (LAT - 2) @(negedge clk);
        check("midrst_level_early", 32'(level_o), 32'h0);
        @(negedge clk);
        check("midrst_level_late", 32'(level_o), 32'b1000);

        // drain the scoreboard
        for (int t = 0; t < 30 && exp_q.size() > 0; t++) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL pulse_never_seen: got none, expected rise=%b fall=%b at cycle %0d",
                     e.rise, e.fall, e.cyc);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
